store_data_gen: RTL



---
 rtl/store_data_gen_pkg.sv | 32 +++
 rtl/store_data_gen_if.sv | 24 ++
 rtl/store_data_gen_lane_align.sv | 27 ++
 rtl/store_data_gen.sv | 138 +++++++++++++
 4 files changed

// File: rtl/store_data_gen_pkg.sv
// Shared types and constants for the store data path.
// Optional feature macro: STORE_MISALIGN_SPLIT_EN (split misaligned stores into two beats).
package store_data_gen_pkg;

  localparam int SDG_ADDR_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [3:0] MASK_BYTE = 4'h1;
  localparam logic [3:0] MASK_HALF = 4'h3;
  localparam logic [3:0] MASK_WORD = 4'hF;

  typedef enum logic [1:0] {ST_IDLE, ST_ONE, ST_TWO} sdg_state_e;

  typedef struct packed {
    logic [SDG_ADDR_W-1:0] addr;
    logic [31:0]           data;
    logic [3:0]            strb;
  } store_beat_t;

  // Size code 2'b11 behaves as a word store.
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: size_mask = MASK_BYTE;
      SZ_HALF: size_mask = MASK_HALF;
      default: size_mask = MASK_WORD;
    endcase
  endfunction

endpackage

// File: rtl/store_data_gen_if.sv
// Request and write-beat handshake bundle for store_data_gen.
interface store_data_gen_if #(parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic [31:0]       req_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic              misalign_err;

  modport master (
    output req_valid, req_addr, req_size, req_data, wr_ready,
    input  req_ready, wr_valid, wr_addr, wr_data, wr_strb, misalign_err
  );

  modport slave (
    input  req_valid, req_addr, req_size, req_data, wr_ready,
    output req_ready, wr_valid, wr_addr, wr_data, wr_strb, misalign_err
  );
endinterface

// File: rtl/store_data_gen_lane_align.sv
// store_lane_align: places right-justified store data onto byte lanes of a
// two-word window. Purely combinational so a merge buffer can reuse it.
module store_lane_align
  import store_data_gen_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_data,
  output logic [63:0] o_data64,
  output logic [7:0]  o_strb64
);

  logic [3:0]  w_mask;
  logic [31:0] w_masked;

  // Expand the byte mask to a bit mask so bytes above the size are cleared.
  always_comb begin
    w_mask   = size_mask(i_size);
    w_masked = '0;
    for (int b = 0; b < 4; b++)
      w_masked[8*b +: 8] = w_mask[b] ? i_data[8*b +: 8] : 8'h00;
  end

  assign o_data64 = {32'h0, w_masked} << {i_off, 3'b000};
  assign o_strb64 = {4'h0, w_mask} << i_off;

endmodule

// File: rtl/store_data_gen.sv
// store_data_gen: turns a store request into a registered, word-aligned write
// beat with byte strobes. Define STORE_MISALIGN_SPLIT_EN to split stores that
// cross a word into two beats; otherwise such stores are dropped and flagged.
module store_data_gen
  import store_data_gen_pkg::*;
#(
  parameter int ADDR_W = SDG_ADDR_W
) (
  input logic            clk,
  input logic            rst,
  store_data_gen_if.slave bus
);

  logic [63:0]       w_data64;
  logic [7:0]        w_strb64;
  logic [ADDR_W-1:0] w_lo_addr;
  store_beat_t       w_lo_beat;
  logic              w_mis;
  logic              w_wr_valid;
  logic              w_pending;
  logic              w_req_ready;
  logic              w_accept;
  logic              w_ld_lo;

  sdg_state_e        r_state;
  sdg_state_e        w_nxt;
  store_beat_t       r_out;

  store_lane_align u_align (
    .i_off    (bus.req_addr[1:0]),
    .i_size   (bus.req_size),
    .i_data   (bus.req_data),
    .o_data64 (w_data64),
    .o_strb64 (w_strb64)
  );

  assign w_lo_addr = {bus.req_addr[ADDR_W-1:2], 2'b00};
  assign w_lo_beat = '{addr: w_lo_addr, data: w_data64[31:0], strb: w_strb64[3:0]};
  assign w_mis     = |w_strb64[7:4];

  assign w_wr_valid  = (r_state != ST_IDLE);
  assign w_req_ready = ~w_pending & (~w_wr_valid | bus.wr_ready);
  assign w_accept    = bus.req_valid & w_req_ready;

  assign bus.req_ready = w_req_ready;
  assign bus.wr_valid  = w_wr_valid;
  assign bus.wr_addr   = r_out.addr;
  assign bus.wr_data   = r_out.data;
  assign bus.wr_strb   = r_out.strb;

`ifdef STORE_MISALIGN_SPLIT_EN
  store_beat_t r_pend;
  store_beat_t w_hi_beat;
  logic        w_ld_pend;
  logic        w_ld_hi;

  // High beat lands in the next word; the address wraps at the top of memory.
  assign w_hi_beat = '{addr: w_lo_addr + {{(ADDR_W-3){1'b0}}, 3'b100},
                       data: w_data64[63:32], strb: w_strb64[7:4]};
  assign w_pending = (r_state == ST_TWO);
  assign bus.misalign_err = 1'b0;

  // Next-state and load selects for the split-capable handshake FSM.
  always_comb begin
    w_nxt     = r_state;
    w_ld_lo   = 1'b0;
    w_ld_pend = 1'b0;
    w_ld_hi   = 1'b0;
    case (r_state)
      ST_TWO: begin
        if (bus.wr_ready) begin
          w_nxt   = ST_ONE;
          w_ld_hi = 1'b1;
        end
      end
      default: begin
        if (w_accept && !w_mis) begin
          w_nxt   = ST_ONE;
          w_ld_lo = 1'b1;
        end else if (w_accept && w_mis) begin
          w_nxt     = ST_TWO;
          w_ld_lo   = 1'b1;
          w_ld_pend = 1'b1;
        end else if (r_state == ST_ONE && bus.wr_ready) begin
          w_nxt = ST_IDLE;
        end
      end
    endcase
  end

  // State, output beat and pending high beat; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_out   <= '0;
      r_pend  <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_ld_lo)      r_out <= w_lo_beat;
      else if (w_ld_hi) r_out <= r_pend;
      if (w_ld_pend)    r_pend <= w_hi_beat;
    end
  end
`else
  logic        r_err;
  logic [31:0] w_unused_hi;

  assign w_unused_hi      = w_data64[63:32];
  assign w_pending        = 1'b0;
  assign bus.misalign_err = r_err;

  // Next-state and load select; a misaligned accept leaves the beat path alone.
  always_comb begin
    w_nxt   = r_state;
    w_ld_lo = 1'b0;
    if (w_accept && !w_mis) begin
      w_nxt   = ST_ONE;
      w_ld_lo = 1'b1;
    end else if (r_state == ST_ONE && bus.wr_ready) begin
      w_nxt = ST_IDLE;
    end
  end

  // State, output beat and one-cycle misalignment pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_out   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_err   <= w_accept & w_mis;
      if (w_ld_lo) r_out <= w_lo_beat;
    end
  end
`endif

endmodule
